// File: rtl/nios_system_pio_pkg.sv
// Shared definitions for the Nios II system PIO blocks:
// register address map and the auto-revert timer state type.
package nios_system_pio_pkg;

    // Avalon-MM register map (2-bit word address)
    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_TIMER    = 2'd1;
    localparam logic [1:0] PIO_ADDR_OUTSET   = 2'd2;
    localparam logic [1:0] PIO_ADDR_OUTCLEAR = 2'd3;

    // One-shot auto-revert timer states
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } tmr_state_e;

    // Atomic read-modify-write of the output register
    function automatic logic [31:0] pio_set_clr(
        input logic [31:0] cur,
        input logic [31:0] msk,
        input logic        set
    );
        return set ? (cur | msk) : (cur & ~msk);
    endfunction

endpackage

// File: rtl/nios_system_pio_timeout_counter.sv
// One-shot down-counter for the output PIO auto-revert feature.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   i_load           TIMER register write strobe
//   i_load_val       value written (0 cancels, nonzero arms)
//   o_count          current count (for TIMER readback)
//   o_expire_now     high in the cycle whose edge takes count 1->0
//   o_expired        registered one-cycle expiry pulse
module nios_system_pio_timeout_counter
    import nios_system_pio_pkg::*;
#(
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [TIMER_WIDTH-1:0] i_load_val,
    output logic [TIMER_WIDTH-1:0] o_count,
    output logic                   o_expire_now,
    output logic                   o_expired
);

    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

    tmr_state_e             r_state;
    tmr_state_e             w_state_nxt;
    logic [TIMER_WIDTH-1:0] r_count;
    logic [TIMER_WIDTH-1:0] w_count_nxt;
    logic                   r_expired;
    logic                   w_expire_now;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_expired <= w_expire_now;
        end
    end

    // Next state: a load always wins over the running count,
    // which is what makes a reload on the expiry cycle suppress it.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (i_load) begin
            w_count_nxt = i_load_val;
            w_state_nxt = (i_load_val != '0) ? ARMED : IDLE;
        end else if (r_state == ARMED) begin
            if (r_count > ONE) begin
                w_count_nxt = r_count - ONE;
            end else begin
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        end
    end

    // Outputs
    always_comb begin
        w_expire_now = 1'b0;
        if (r_state == ARMED && r_count == ONE && !i_load) begin
            w_expire_now = 1'b1;
        end
    end

    assign o_count      = r_count;
    assign o_expire_now = w_expire_now;
    assign o_expired    = r_expired;

endmodule

// File: rtl/nios_system_eight_bit_output.sv
// Avalon-MM output PIO with atomic set/clear and optional
// one-shot auto-revert timer (EIGHT_BIT_OUTPUT_TIMEOUT_EN).
// Ports:
//   clk, reset_n     clock, async active-low reset
//   address          register select (DATA/TIMER/OUTSET/OUTCLEAR)
//   chipselect       slave select, qualifies write_n
//   write_n          active-low write strobe
//   writedata        32-bit write data
//   readdata         registered read data, zero-extended
//   out_port         output pins (mirror of data register)
//   expired          one-cycle pulse on timer revert
module nios_system_eight_bit_output
    import nios_system_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    TIMER_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  expired
);

    logic [DATA_WIDTH-1:0]  r_data;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic [31:0]            r_readdata;
    logic [31:0]            w_rd_nxt;
    logic                   w_wr;
    logic [DATA_WIDTH-1:0]  w_wd;
    logic [TIMER_WIDTH-1:0] w_count;
    logic                   w_expire_now;
    logic                   w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[DATA_WIDTH-1:0];
    assign w_unused = &{1'b0, writedata};

`ifdef EIGHT_BIT_OUTPUT_TIMEOUT_EN
    logic w_load;

    assign w_load = w_wr && (address == PIO_ADDR_TIMER);

    nios_system_pio_timeout_counter #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_load_val   (writedata[TIMER_WIDTH-1:0]),
        .o_count      (w_count),
        .o_expire_now (w_expire_now),
        .o_expired    (expired)
    );
`else
    assign w_count      = '0;
    assign w_expire_now = 1'b0;
    assign expired      = 1'b0;
`endif

    // Data register next value: a CPU write overrides a
    // simultaneous timer revert.
    always_comb begin
        w_data_nxt = r_data;
        if (w_expire_now) begin
            w_data_nxt = RESET_VALUE;
        end
        if (w_wr) begin
            case (address)
                PIO_ADDR_DATA:
                    w_data_nxt = w_wd;
                PIO_ADDR_OUTSET:
                    w_data_nxt = r_data | w_wd;
                PIO_ADDR_OUTCLEAR:
                    w_data_nxt = r_data & ~w_wd;
                default: ;
            endcase
        end
    end

    // Read mux, sampled every clock (no read strobe)
    always_comb begin
        w_rd_nxt = '0;
        case (address)
            PIO_ADDR_DATA:
                w_rd_nxt[DATA_WIDTH-1:0] = r_data;
            PIO_ADDR_TIMER:
                w_rd_nxt[TIMER_WIDTH-1:0] = w_count;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= RESET_VALUE;
            r_readdata <= '0;
        end else begin
            r_data     <= w_data_nxt;
            r_readdata <= w_rd_nxt;
        end
    end

    assign out_port = r_data;
    assign readdata = r_readdata;

endmodule

// File: tb/tb_nios_system_eight_bit_output.sv
// Scoreboard bench for the output PIO: random and directed bus
// traffic against a behavioural model of the register map.
`timescale 1ns/1ps
module tb_nios_system_eight_bit_output;

`ifdef EIGHT_BIT_OUTPUT_TIMEOUT_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam logic [7:0] RV = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        expired;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  op;
        logic        ex;
        int          id;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_id  = 0;

    logic [7:0]  m_data;
    int unsigned m_count;
    bit          m_armed;

    always #5 clk = ~clk;

    nios_system_eight_bit_output #(
        .DATA_WIDTH  (8),
        .RESET_VALUE (RV),
        .TIMER_WIDTH (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .expired    (expired)
    );

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d got=%h exp=%h",
                     nm, id, act, exp);
        end
    endtask

    // Apply one bus cycle; called at posedge+2.
    task automatic step(input logic cs, input logic wn,
                        input logic [1:0] a,
                        input logic [31:0] wd);
        exp_t        e;
        bit          wr;
        bit          ex;
        logic [7:0]  nd;
        int unsigned nc;
        bit          na;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        wr = cs && !wn;
        e.rd = 32'h0;
        if (a == 2'd0) e.rd = {24'h0, m_data};
        if (a == 2'd1) e.rd = m_count;
        ex = 1'b0;
        nd = m_data;
        nc = m_count;
        na = m_armed;
        if (TMR) begin
            if (wr && a == 2'd1) begin
                nc = wd & 32'hFFFF;
                na = (nc != 0);
            end else if (m_armed) begin
                nc = m_count - 1;
                if (nc == 0) begin
                    na = 1'b0;
                    ex = 1'b1;
                end
            end
        end
        if (ex) nd = RV;
        if (wr && a == 2'd0) nd = wd[7:0];
        if (wr && a == 2'd2) nd = m_data | wd[7:0];
        if (wr && a == 2'd3) nd = m_data & ~wd[7:0];
        m_data  = nd;
        m_count = nc;
        m_armed = na;
        e.op = nd;
        e.ex = ex;
        e.id = n_id++;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic wr_reg(input logic [1:0] a,
                          input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        step(1'b1, 1'b1, a, 32'h0);
    endtask

    // Monitor: compares DUT outputs one time unit after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("readdata", e.id, readdata, e.rd);
                chk("out_port", e.id, {24'h0, out_port},
                    {24'h0, e.op});
                chk("expired", e.id, {31'h0, expired},
                    {31'h0, e.ex});
            end
        end
    end

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        #3;
        chk("rst_out_port", 0, {24'h0, out_port}, {24'h0, RV});
        chk("rst_readdata", 0, readdata, 32'h0);
        chk("rst_expired", 0, {31'h0, expired}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_hold_out", 0, {24'h0, out_port}, {24'h0, RV});
        m_data  = RV;
        m_count = 0;
        m_armed = 1'b0;
        reset_n = 1'b1;

        // basic write/readback
        wr_reg(2'd0, 32'h000000A5);
        rd_reg(2'd0);
        rd_reg(2'd0);
        // set/clear
        wr_reg(2'd0, 32'hFFFFFFF0);
        wr_reg(2'd2, 32'h0000000F);
        wr_reg(2'd3, 32'h00000081);
        rd_reg(2'd2);
        rd_reg(2'd3);
        rd_reg(2'd0);
        // one-shot revert
        wr_reg(2'd0, 32'h3C);
        wr_reg(2'd1, 32'd5);
        repeat (7) rd_reg(2'd1);
        // reload on the expiry cycle
        wr_reg(2'd0, 32'h3C);
        wr_reg(2'd1, 32'd3);
        rd_reg(2'd1);
        rd_reg(2'd1);
        wr_reg(2'd1, 32'd10);
        repeat (12) rd_reg(2'd0);
        // data write on the expiry cycle
        wr_reg(2'd1, 32'd2);
        rd_reg(2'd0);
        wr_reg(2'd0, 32'h55);
        rd_reg(2'd1);
        rd_reg(2'd0);
        // cancel
        wr_reg(2'd1, 32'd4);
        wr_reg(2'd1, 32'd0);
        repeat (6) rd_reg(2'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            a = 2'($urandom_range(0, 3));
            d = $urandom;
            if (a == 2'd1)
                d = (d & 32'hFFFF0000) | $urandom_range(0, 12);
            step(1'($urandom), 1'($urandom), a, d);
        end

        // async reset while counting
        wr_reg(2'd0, 32'h99);
        wr_reg(2'd1, 32'd100);
        repeat (3) rd_reg(2'd1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #2;
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_out_port", n_id, {24'h0, out_port},
            {24'h0, RV});
        chk("async_expired", n_id, {31'h0, expired}, 32'h0);
        chk("async_readdata", n_id, readdata, 32'h0);
        m_data  = RV;
        m_count = 0;
        m_armed = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        rd_reg(2'd1);
        rd_reg(2'd1);
        rd_reg(2'd0);
        repeat (4) step(1'b0, 1'b1, 2'd0, 32'h0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
